// File: rtl/dpic_sram_arbiter.sv
// rtl/dpic_sram_arbiter.sv - round-robin arbiter sharing one DPIC_SRAM-style port between fetch (r0) and LSU (r1)
// One transaction in flight at a time; the response is routed back to the owner.
module dpic_sram_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   r0_req,
  input  logic [ADDR_WIDTH-1:0]  r0_addr,
  input  logic [WMASK_WIDTH-1:0] r0_wmask,
  input  logic [1:0]             r0_size,
  input  logic [DATA_WIDTH-1:0]  r0_wdata,
  output logic                   r0_ready,
  output logic                   r0_rvalid,
  output logic [DATA_WIDTH-1:0]  r0_rdata,

  input  logic                   r1_req,
  input  logic [ADDR_WIDTH-1:0]  r1_addr,
  input  logic [WMASK_WIDTH-1:0] r1_wmask,
  input  logic [1:0]             r1_size,
  input  logic [DATA_WIDTH-1:0]  r1_wdata,
  output logic                   r1_ready,
  output logic                   r1_rvalid,
  output logic [DATA_WIDTH-1:0]  r1_rdata,

  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WMASK_WIDTH-1:0] mem_wmask,
  output logic [1:0]             mem_size,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_stall,
  input  logic                   mem_valid
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last_grant;
  logic   is_write;

  logic                   any_req;
  logic                   winner;
  logic                   accept;
  logic [WMASK_WIDTH-1:0] win_wmask;
  logic [DATA_WIDTH-1:0]  resp_data;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    any_req   = r0_req | r1_req;
    winner    = (r0_req & r1_req) ? ~last_grant : r1_req;
    win_wmask = winner ? r1_wmask : r0_wmask;
    resp_data = is_write ? '0 : mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_size  = '0;
    mem_wdata = '0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    r0_rdata  = '0;
    r1_rdata  = '0;

    // Everything stays quiet under reset, which also drops any pending response.
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            mem_req   = 1'b1;
            mem_addr  = winner ? r1_addr  : r0_addr;
            mem_wmask = win_wmask;
            mem_size  = winner ? r1_size  : r0_size;
            mem_wdata = winner ? r1_wdata : r0_wdata;
            if (!mem_stall) begin
              accept    = 1'b1;
              r0_ready  = ~winner;
              r1_ready  = winner;
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_valid) begin
            r0_rvalid = ~owner;
            r1_rvalid = owner;
            r0_rdata  = owner ? '0 : resp_data;
            r1_rdata  = owner ? resp_data : '0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      is_write   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        is_write   <= |win_wmask;
      end
    end
  end

endmodule

// File: tb/tb_dpic_sram_arbiter.sv
// tb/tb_dpic_sram_arbiter.sv - self-checking bench for dpic_sram_arbiter
// Transaction-level reference model plus directed scenarios and random traffic.
module tb_dpic_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 5;

  logic          clk;
  logic          rst;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [MW-1:0] r0_wmask, r1_wmask;
  logic [1:0]    r0_size, r1_size;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall, mem_valid;

  dpic_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wmask(r0_wmask), .r0_size(r0_size),
    .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wmask(r1_wmask), .r1_size(r1_size),
    .r1_wdata(r1_wdata), .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_valid(mem_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic who;
    logic wr;
  } txn_t;

  // Model: list of transactions granted but not yet answered, plus who won last.
  txn_t inflight[$];
  logic m_last = 1'b1;

  // Values seen at the last compare, used by directed literal checks.
  logic          s_r0_ready, s_r1_ready, s_r0_rvalid, s_r1_rvalid, s_mem_req;
  logic [DW-1:0] s_r0_rdata, s_r1_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [MW-1:0] s_mem_wmask;
  logic [1:0]    s_mem_size;
  logic          acc0, acc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic          w;
    logic          e_mreq, e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_wmask;
    logic [1:0]    e_size;
    logic [DW-1:0] e_wdata, e_rd0, e_rd1;
    #1;
    e_mreq = 0; e_rdy0 = 0; e_rdy1 = 0; e_rv0 = 0; e_rv1 = 0;
    e_addr = '0; e_wmask = '0; e_size = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    w = 1'b0;
    if (!rst) begin
      if (inflight.size() == 0) begin
        if (r0_req || r1_req) begin
          if (r0_req && r1_req) w = (m_last == 1'b0);
          else                  w = r1_req;
          e_mreq  = 1;
          e_addr  = w ? r1_addr  : r0_addr;
          e_wmask = w ? r1_wmask : r0_wmask;
          e_size  = w ? r1_size  : r0_size;
          e_wdata = w ? r1_wdata : r0_wdata;
          if (!mem_stall) begin
            if (w) e_rdy1 = 1; else e_rdy0 = 1;
          end
        end
      end else if (mem_valid) begin
        if (inflight[0].who) begin
          e_rv1 = 1;
          e_rd1 = inflight[0].wr ? '0 : mem_rdata;
        end else begin
          e_rv0 = 1;
          e_rd0 = inflight[0].wr ? '0 : mem_rdata;
        end
      end
    end

    check("r0_ready",  32'(r0_ready),  32'(e_rdy0));
    check("r1_ready",  32'(r1_ready),  32'(e_rdy1));
    check("r0_rvalid", 32'(r0_rvalid), 32'(e_rv0));
    check("r1_rvalid", 32'(r1_rvalid), 32'(e_rv1));
    check("r0_rdata",  r0_rdata,       e_rd0);
    check("r1_rdata",  r1_rdata,       e_rd1);
    check("mem_req",   32'(mem_req),   32'(e_mreq));
    check("mem_addr",  mem_addr,       e_addr);
    check("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
    check("mem_size",  32'(mem_size),  32'(e_size));
    check("mem_wdata", mem_wdata,      e_wdata);

    s_r0_ready = r0_ready;   s_r1_ready = r1_ready;
    s_r0_rvalid = r0_rvalid; s_r1_rvalid = r1_rvalid;
    s_r0_rdata = r0_rdata;   s_r1_rdata = r1_rdata;
    s_mem_req = mem_req;     s_mem_addr = mem_addr;
    s_mem_wmask = mem_wmask; s_mem_size = mem_size; s_mem_wdata = mem_wdata;
    acc0 = e_rdy0; acc1 = e_rdy1;

    if (rst) begin
      inflight.delete();
      m_last = 1'b1;
    end else if (e_rdy0 || e_rdy1) begin
      inflight.push_back('{who: w, wr: |e_wmask});
      m_last = w;
    end else if (e_rv0 || e_rv1) begin
      void'(inflight.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  logic [5:0] t3_r0_ready, t3_r1_ready, t3_r0_rvalid, t3_r1_rvalid;

  initial begin
    rst = 1; r0_req = 0; r1_req = 0;
    r0_addr = '0; r0_wmask = '0; r0_size = '0; r0_wdata = '0;
    r1_addr = '0; r1_wmask = '0; r1_size = '0; r1_wdata = '0;
    mem_rdata = '0; mem_stall = 0; mem_valid = 1;
    acc0 = 0; acc1 = 0;
    @(posedge clk);
    #1;
    r0_req = 1; r1_req = 1;
    cycle();
    check("rst_mem_req", 32'(s_mem_req), 32'd0);
    check("rst_ready",   32'({s_r0_ready, s_r1_ready}), 32'd0);

    // 1: r0 read
    rst = 0; r1_req = 0;
    r0_req = 1; r0_addr = 32'h8000_0000; r0_size = 2'd2; r0_wmask = '0;
    mem_rdata = 32'h1234_5678;
    cycle();
    check("t1_r0_ready", 32'(s_r0_ready), 32'd1);
    check("t1_mem_addr", s_mem_addr, 32'h8000_0000);
    check("t1_mem_size", 32'(s_mem_size), 32'd2);
    r0_req = 0;
    cycle();
    check("t1_r0_rvalid", 32'(s_r0_rvalid), 32'd1);
    check("t1_r0_rdata",  s_r0_rdata, 32'h1234_5678);
    check("t1_r1_rvalid", 32'(s_r1_rvalid), 32'd0);

    // 2: r1 write
    r1_req = 1; r1_addr = 32'h100; r1_wmask = 5'hF; r1_wdata = 32'hDEAD_BEEF; r1_size = 2'd2;
    cycle();
    check("t2_r1_ready",  32'(s_r1_ready), 32'd1);
    check("t2_mem_wmask", 32'(s_mem_wmask), 32'hF);
    check("t2_mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
    r1_req = 0;
    cycle();
    check("t2_r1_rvalid", 32'(s_r1_rvalid), 32'd1);
    check("t2_r1_rdata",  s_r1_rdata, 32'd0);

    // 3: both held for six cycles
    r0_req = 1; r1_req = 1; r0_addr = 32'h40; r1_addr = 32'h80; r1_wmask = '0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      t3_r0_ready[i] = s_r0_ready;   t3_r1_ready[i] = s_r1_ready;
      t3_r0_rvalid[i] = s_r0_rvalid; t3_r1_rvalid[i] = s_r1_rvalid;
    end
    check("t3_r0_ready",  32'(t3_r0_ready),  32'b010001);
    check("t3_r1_ready",  32'(t3_r1_ready),  32'b000100);
    check("t3_r0_rvalid", 32'(t3_r0_rvalid), 32'b100010);
    check("t3_r1_rvalid", 32'(t3_r1_rvalid), 32'b001000);
    r0_req = 0; r1_req = 0;
    cycle();

    // 4: memory stall holds off r1
    r1_req = 1; r1_addr = 32'h200; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_stall_ready", 32'(s_r1_ready), 32'd0);
      check("t4_stall_req",   32'(s_mem_req), 32'd1);
    end
    mem_stall = 0;
    cycle();
    check("t4_ready", 32'(s_r1_ready), 32'd1);
    r1_req = 0;
    cycle();
    check("t4_rvalid", 32'(s_r1_rvalid), 32'd1);

    // 5: reset while waiting
    r0_req = 1; r0_addr = 32'h300;
    cycle();
    check("t5_grant", 32'(s_r0_ready), 32'd1);
    rst = 1; r1_req = 1;
    cycle();
    check("t5_no_rvalid", 32'({s_r0_rvalid, s_r1_rvalid}), 32'd0);
    check("t5_rst_quiet", 32'({s_mem_req, s_r0_ready, s_r1_ready}), 32'd0);
    rst = 0;
    cycle();
    check("t5_tie_r0", 32'({s_r0_ready, s_r1_ready}), 32'b10);
    r0_req = 0; r1_req = 0;
    cycle();

    // 6: r1 arrives while r0 is waiting
    r0_req = 1; r0_addr = 32'h400;
    cycle();
    check("t6_r0_ready", 32'(s_r0_ready), 32'd1);
    r0_req = 0; mem_valid = 0;
    r1_req = 1; r1_addr = 32'h2000; r1_wmask = 5'h3; r1_wdata = 32'hCAFE_0001;
    cycle();
    check("t6_wait_ready", 32'(s_r1_ready), 32'd0);
    mem_valid = 1;
    cycle();
    check("t6_r0_rvalid", 32'(s_r0_rvalid), 32'd1);
    check("t6_ignored",   32'(s_r1_ready), 32'd0);
    cycle();
    check("t6_r1_ready", 32'(s_r1_ready), 32'd1);
    check("t6_addr",     s_mem_addr, 32'h2000);
    check("t6_wdata",    s_mem_wdata, 32'hCAFE_0001);
    r1_req = 0;
    cycle();

    // random traffic; requests are held until the model says they were accepted
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (acc0) r0_req = 0;
      if (acc1) r1_req = 0;
      if (!r0_req && $urandom_range(0, 2) == 0) begin
        r0_req   = 1;
        r0_addr  = $urandom;
        r0_wmask = ($urandom_range(0, 1) == 1) ? MW'($urandom_range(1, 31)) : '0;
        r0_size  = 2'($urandom_range(0, 3));
        r0_wdata = $urandom;
      end
      if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_req   = 1;
        r1_addr  = $urandom;
        r1_wmask = ($urandom_range(0, 1) == 1) ? MW'($urandom_range(1, 31)) : '0;
        r1_size  = 2'($urandom_range(0, 3));
        r1_wdata = $urandom;
      end
      mem_stall = ($urandom_range(0, 3) == 0);
      mem_valid = ($urandom_range(0, 9) < 7);
      mem_rdata = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
